// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM read-side streamer.
// Holds the default SRAM geometry and the read-engine state encoding
// so the top level, the bus interface and the testbench all agree.
package sram_pkg;

   localparam int SRAM_AWIDTH = 12;
   localparam int SRAM_DWIDTH = 72;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

endpackage

// File: rtl/sram_rd_streamer_if.sv
// Bus bundle for the read streamer: the SRAM read port (port B) plus the
// outgoing valid/ready word stream.
//   mem_en, regceb, addrb : read request, output enable and address to SRAM
//   doutb                 : combinational read data back from SRAM
//   m_valid, m_data,
//   m_last, m_ready       : output stream towards the consumer
// master = the streamer, slave = the SRAM model / consumer side.
interface sram_rd_streamer_if
   import sram_pkg::*;
#(
   parameter int AWIDTH = SRAM_AWIDTH,
   parameter int DWIDTH = SRAM_DWIDTH
);

   logic              mem_en;
   logic              regceb;
   logic [AWIDTH-1:0] addrb;
   logic [DWIDTH-1:0] doutb;
   logic              m_valid;
   logic [DWIDTH-1:0] m_data;
   logic              m_last;
   logic              m_ready;

   modport master (
      output mem_en, regceb, addrb, m_valid, m_data, m_last,
      input  doutb, m_ready
   );

   modport slave (
      input  mem_en, regceb, addrb, m_valid, m_data, m_last,
      output doutb, m_ready
   );

endinterface

// File: rtl/stream_skid2.sv
// Two-entry output FIFO of {last, data} presented as a valid/ready stream.
//   clk, rstb          : clock, async active-low reset
//   push, push_data,
//   push_last          : write one entry (ignored when full and not popping)
//   flush              : drop all entries at the next edge, wins over push
//   cnt                : current occupancy 0..2
//   m_valid, m_data,
//   m_last, m_ready    : stream side; a pop is m_valid & m_ready
// The head entry lives directly in the output registers so the stream
// outputs are registered and stay stable while the consumer stalls.
module stream_skid2 #(
   parameter int DWIDTH = 72
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              push_last,
   input  logic              flush,
   output logic [1:0]        cnt,
   output logic              m_valid,
   output logic [DWIDTH-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready
);

   logic [DWIDTH-1:0] tail_data;
   logic              tail_last;

   logic [1:0]        cnt_n;
   logic [DWIDTH-1:0] head_data_n;
   logic              head_last_n;
   logic [DWIDTH-1:0] tail_data_n;
   logic              tail_last_n;
   logic              pop;

   assign pop = m_valid & m_ready;

   // Next-state of the two slots. When both slots are full a pop shifts the
   // tail into the head, and a simultaneous push refills the tail. The head
   // last flag is cleared whenever the FIFO empties so m_last never shows a
   // stale marker without m_valid.
   always_comb begin
      cnt_n       = cnt;
      head_data_n = m_data;
      head_last_n = m_last;
      tail_data_n = tail_data;
      tail_last_n = tail_last;
      if (flush) begin
         cnt_n       = 2'd0;
         head_last_n = 1'b0;
      end else begin
         case (cnt)
            2'd0: begin
               if (push) begin
                  head_data_n = push_data;
                  head_last_n = push_last;
                  cnt_n       = 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  head_data_n = push_data;
                  head_last_n = push_last;
               end else if (push) begin
                  tail_data_n = push_data;
                  tail_last_n = push_last;
                  cnt_n       = 2'd2;
               end else if (pop) begin
                  head_last_n = 1'b0;
                  cnt_n       = 2'd0;
               end
            end
            2'd2: begin
               if (pop) begin
                  head_data_n = tail_data;
                  head_last_n = tail_last;
                  if (push) begin
                     tail_data_n = push_data;
                     tail_last_n = push_last;
                  end else begin
                     cnt_n = 2'd1;
                  end
               end
            end
            default: begin
               cnt_n       = 2'd0;
               head_last_n = 1'b0;
            end
         endcase
      end
   end

   // Storage and output registers.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt       <= 2'd0;
         m_valid   <= 1'b0;
         m_data    <= '0;
         m_last    <= 1'b0;
         tail_data <= '0;
         tail_last <= 1'b0;
      end else begin
         cnt       <= cnt_n;
         m_valid   <= (cnt_n != 2'd0);
         m_data    <= head_data_n;
         m_last    <= head_last_n;
         tail_data <= tail_data_n;
         tail_last <= tail_last_n;
      end
   end

endmodule

// File: rtl/sram_rd_streamer.sv
// Read-side engine for the simple dual-port SRAM.
// On an accepted start it reads len consecutive words from base_addr
// (wrapping modulo 2^AWIDTH) and streams them out with a last marker.
//   clk, rstb      : clock, async active-low reset
//   start          : command strobe, accepted only when idle
//   base_addr, len : transfer description latched on an accepted start
//   abort          : cancel an active transfer (no done)
//   busy           : high while a transfer is active
//   done           : one-cycle completion pulse
//   bus            : SRAM read port and output stream (master modport)
module sram_rd_streamer
   import sram_pkg::*;
#(
   parameter int AWIDTH = SRAM_AWIDTH,
   parameter int DWIDTH = SRAM_DWIDTH,
   parameter int LWIDTH = AWIDTH + 1
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              start,
   input  logic [AWIDTH-1:0] base_addr,
   input  logic [LWIDTH-1:0] len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   sram_rd_streamer_if.master bus
);

   rd_state_e         state;
   rd_state_e         state_n;
   logic [AWIDTH-1:0] rd_addr;
   logic [LWIDTH-1:0] remain;
   logic [1:0]        cnt;
   logic              hs;
   logic              issue;
   logic              last_issue;
   logic              flush;
   logic              done_n;
   logic              accept;

   assign hs     = bus.m_valid & bus.m_ready;
   assign accept = (state == IDLE) && start && (len != '0);

   // A read may issue whenever the buffer has a free slot, or when it is
   // full but the head is leaving this very cycle. The SRAM data is
   // combinational, so it is captured into the buffer at the same edge.
   assign issue      = (state == READ) &&
                       ((cnt < 2'd2) || ((cnt == 2'd2) && hs));
   assign last_issue = issue && (remain == LWIDTH'(1));

   assign bus.mem_en = issue;
   assign bus.regceb = issue;
   assign bus.addrb  = rd_addr;

   // Next-state and command decode. Abort wins over everything in the
   // active states and suppresses done. A zero-length start never leaves
   // IDLE; it only produces the done pulse.
   always_comb begin
      state_n = state;
      done_n  = 1'b0;
      flush   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  state_n = READ;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         READ: begin
            if (abort) begin
               state_n = IDLE;
               flush   = 1'b1;
            end else if (last_issue) begin
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (abort) begin
               state_n = IDLE;
               flush   = 1'b1;
            end else if (hs && bus.m_last) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            flush   = 1'b1;
         end
      endcase
   end

   // State, busy and done are registered so the command side sees
   // glitch-free outputs; busy tracks the state being entered.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         busy  <= (state_n != IDLE);
         done  <= done_n;
      end
   end

   // Address and remaining-word counters. rd_addr only moves on a load or
   // an issue, which keeps addrb steady while reads are stalled. The
   // increment wraps naturally at the address width.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         rd_addr <= '0;
         remain  <= '0;
      end else if (accept) begin
         rd_addr <= base_addr;
         remain  <= len;
      end else if (issue) begin
         rd_addr <= rd_addr + AWIDTH'(1);
         remain  <= remain - LWIDTH'(1);
      end
   end

   stream_skid2 #(
      .DWIDTH (DWIDTH)
   ) u_skid (
      .clk       (clk),
      .rstb      (rstb),
      .push      (issue),
      .push_data (bus.doutb),
      .push_last (last_issue),
      .flush     (flush),
      .cnt       (cnt),
      .m_valid   (bus.m_valid),
      .m_data    (bus.m_data),
      .m_last    (bus.m_last),
      .m_ready   (bus.m_ready)
   );

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Directed testbench for sram_rd_streamer with a combinational SRAM model.
// Each memory word is {8'h5A, 52'd0, address}, so the expected stream data
// follows directly from the address sequence.
module tb_sram_rd_streamer;

   localparam int AW = 12;
   localparam int DW = 72;
   localparam int LW = AW + 1;

   logic          clk;
   logic          rstb;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [LW-1:0] len;
   logic          abort;
   logic          busy;
   logic          done;

   int checks;
   int errors;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   sram_rd_streamer_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

   sram_rd_streamer #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) dut (
      .clk       (clk),
      .rstb      (rstb),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM port B model: data is combinational from the address while enabled.
   always_comb begin
      if (bus.mem_en && bus.regceb) bus.doutb = mem[bus.addrb];
      else                          bus.doutb = '0;
   end

   function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
      return {8'h5A, 52'd0, a};
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
      base_addr = b;
      len       = l;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic test_reset();
      rstb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, bus.m_valid, bus.m_last, bus.mem_en, bus.regceb} !== 6'b0 ||
          bus.addrb !== '0 || bus.m_data !== '0) begin
         errors++;
         $display("[TB] FAIL reset_hold: flags=%b addrb=%h data=%h required all zero",
                  {busy, done, bus.m_valid, bus.m_last, bus.mem_en, bus.regceb},
                  bus.addrb, bus.m_data);
      end
      rstb = 1'b1;
      tick();
      checks++;
      if ({busy, done, bus.m_valid, bus.mem_en} !== 4'b0) begin
         errors++;
         $display("[TB] FAIL reset_release: flags=%b required 0000",
                  {busy, done, bus.m_valid, bus.mem_en});
      end
   endtask

   task automatic test_basic_burst();
      logic [AW-1:0] a;
      bus.m_ready = 1'b1;
      issue_start(12'h010, 13'd4);
      checks++;
      if (bus.mem_en !== 1'b1 || bus.regceb !== 1'b1 || bus.addrb !== 12'h010 ||
          busy !== 1'b1 || bus.m_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_first_read: en=%b ce=%b addrb=%h busy=%b valid=%b required 1 1 010 1 0",
                  bus.mem_en, bus.regceb, bus.addrb, busy, bus.m_valid);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         a = 12'h010 + 12'(k);
         checks++;
         if (bus.m_valid !== 1'b1 || bus.m_data !== word(a) ||
             bus.m_last !== (k == 3) || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_word%0d: valid=%b data=%h last=%b done=%b required 1 %h %b 0",
                     k, bus.m_valid, bus.m_data, bus.m_last, done, word(a), (k == 3));
         end
      end
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || bus.m_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_done: done=%b busy=%b valid=%b required 1 0 0",
                  done, busy, bus.m_valid);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_done_pulse: done=%b required 0", done);
      end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_addr [4];
      exp_addr[0] = 12'hFFE;
      exp_addr[1] = 12'hFFF;
      exp_addr[2] = 12'h000;
      exp_addr[3] = 12'h001;
      bus.m_ready = 1'b1;
      issue_start(12'hFFE, 13'd4);
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            checks++;
            if (bus.mem_en !== 1'b1 || bus.addrb !== exp_addr[k]) begin
               errors++;
               $display("[TB] FAIL wrap_addr%0d: en=%b addrb=%h required 1 %h",
                        k, bus.mem_en, bus.addrb, exp_addr[k]);
            end
         end
         if (k > 0) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== word(exp_addr[k-1])) begin
               errors++;
               $display("[TB] FAIL wrap_data%0d: valid=%b data=%h required 1 %h",
                        k - 1, bus.m_valid, bus.m_data, word(exp_addr[k-1]));
            end
         end
         tick();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wrap_done: done=%b busy=%b required 1 0", done, busy);
      end
   endtask

   task automatic test_backpressure();
      bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [AW-1:0] b = 12'h100;
      int            issued = 0;
      int            delivered = 0;
      int            dones = 0;
      int            occ;
      bit            prev_stall = 1'b0;
      logic [DW-1:0] prev_data = '0;
      bus.m_ready = pat[0];
      issue_start(b, 13'd6);
      for (int c = 1; c < 60 && dones == 0; c++) begin
         bus.m_ready = pat[c % 6];
         #1;
         occ = issued - delivered;
         checks++;
         if (occ > 2 || occ < 0 || bus.m_valid !== (occ != 0)) begin
            errors++;
            $display("[TB] FAIL bp_occupancy c%0d: valid=%b model_count=%0d required valid=%b count<=2",
                     c, bus.m_valid, occ, (occ != 0));
         end
         if (occ == 2 && !bus.m_ready) begin
            checks++;
            if (bus.mem_en !== 1'b0) begin
               errors++;
               $display("[TB] FAIL bp_stall c%0d: mem_en=%b required 0", c, bus.mem_en);
            end
         end
         if (prev_stall) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data) begin
               errors++;
               $display("[TB] FAIL bp_stable c%0d: valid=%b data=%h required 1 %h",
                        c, bus.m_valid, bus.m_data, prev_data);
            end
         end
         if (bus.mem_en === 1'b1) begin
            checks++;
            if (issued >= 6 || bus.addrb !== b + 12'(issued)) begin
               errors++;
               $display("[TB] FAIL bp_issue c%0d: read#%0d addrb=%h required %h within 6 reads",
                        c, issued, bus.addrb, b + 12'(issued));
            end
            issued++;
         end
         if (bus.m_valid === 1'b1 && bus.m_ready) begin
            checks++;
            if (bus.m_data !== word(b + 12'(delivered)) || bus.m_last !== (delivered == 5)) begin
               errors++;
               $display("[TB] FAIL bp_word%0d: data=%h last=%b required %h %b",
                        delivered, bus.m_data, bus.m_last, word(b + 12'(delivered)), (delivered == 5));
            end
            delivered++;
         end
         if (done === 1'b1) dones++;
         prev_stall = bus.m_valid & ~bus.m_ready;
         prev_data  = bus.m_data;
         tick();
      end
      checks++;
      if (issued != 6 || delivered != 6 || dones != 1) begin
         errors++;
         $display("[TB] FAIL bp_totals: reads=%0d words=%0d dones=%0d required 6 6 1",
                  issued, delivered, dones);
      end
      bus.m_ready = 1'b1;
   endtask

   task automatic test_zero_and_ignored();
      logic [AW-1:0] a;
      bus.m_ready = 1'b1;
      base_addr = 12'h020;
      len       = 13'd0;
      start     = 1'b1;
      #1;
      checks++;
      if (bus.mem_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_no_read_c0: mem_en=%b required 0", bus.mem_en);
      end
      tick();
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || bus.mem_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_done: done=%b busy=%b mem_en=%b required 1 0 0",
                  done, busy, bus.mem_en);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || bus.m_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_after: done=%b busy=%b valid=%b required 0 0 0",
                  done, busy, bus.m_valid);
      end
      issue_start(12'h020, 13'd3);
      base_addr = 12'h300;
      len       = 13'd5;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a = 12'h020 + 12'(k);
         checks++;
         if (bus.m_valid !== 1'b1 || bus.m_data !== word(a) || bus.m_last !== (k == 2)) begin
            errors++;
            $display("[TB] FAIL ignored_word%0d: valid=%b data=%h last=%b required 1 %h %b",
                     k, bus.m_valid, bus.m_data, bus.m_last, word(a), (k == 2));
         end
         tick();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ignored_done: done=%b busy=%b required 1 0", done, busy);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || bus.m_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ignored_no_rerun: busy=%b valid=%b required 0 0", busy, bus.m_valid);
      end
   endtask

   task automatic test_abort();
      logic [AW-1:0] a;
      bus.m_ready = 1'b1;
      issue_start(12'h040, 13'd8);
      for (int k = 0; k < 3; k++) begin
         tick();
         a = 12'h040 + 12'(k);
         checks++;
         if (bus.m_valid !== 1'b1 || bus.m_data !== word(a)) begin
            errors++;
            $display("[TB] FAIL abort_word%0d: valid=%b data=%h required 1 %h",
                     k, bus.m_valid, bus.m_data, word(a));
         end
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (bus.m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.mem_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_stop: valid=%b busy=%b done=%b mem_en=%b required 0 0 0 0",
                  bus.m_valid, busy, done, bus.mem_en);
      end
      tick();
      checks++;
      if (done !== 1'b0 || bus.m_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_no_done: done=%b valid=%b required 0 0", done, bus.m_valid);
      end
      issue_start(12'h050, 13'd2);
      for (int k = 0; k < 2; k++) begin
         tick();
         a = 12'h050 + 12'(k);
         checks++;
         if (bus.m_valid !== 1'b1 || bus.m_data !== word(a) || bus.m_last !== (k == 1)) begin
            errors++;
            $display("[TB] FAIL abort_restart_word%0d: valid=%b data=%h last=%b required 1 %h %b",
                     k, bus.m_valid, bus.m_data, bus.m_last, word(a), (k == 1));
         end
      end
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_restart_done: done=%b busy=%b required 1 0", done, busy);
      end
   endtask

   task automatic test_reset_mid();
      logic [AW-1:0] a;
      bus.m_ready = 1'b1;
      issue_start(12'h080, 13'd10);
      tick();
      tick();
      #2;
      rstb = 1'b0;
      #1;
      checks++;
      if ({busy, done, bus.m_valid, bus.m_last, bus.mem_en, bus.regceb} !== 6'b0 ||
          bus.addrb !== '0 || bus.m_data !== '0) begin
         errors++;
         $display("[TB] FAIL reset_async: flags=%b addrb=%h data=%h required all zero",
                  {busy, done, bus.m_valid, bus.m_last, bus.mem_en, bus.regceb},
                  bus.addrb, bus.m_data);
      end
      tick();
      rstb = 1'b1;
      tick();
      issue_start(12'h090, 13'd2);
      for (int k = 0; k < 2; k++) begin
         tick();
         a = 12'h090 + 12'(k);
         checks++;
         if (bus.m_valid !== 1'b1 || bus.m_data !== word(a) || bus.m_last !== (k == 1)) begin
            errors++;
            $display("[TB] FAIL reset_restart_word%0d: valid=%b data=%h last=%b required 1 %h %b",
                     k, bus.m_valid, bus.m_data, bus.m_last, word(a), (k == 1));
         end
      end
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_restart_done: done=%b busy=%b required 1 0", done, busy);
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rstb        = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      base_addr   = '0;
      len         = '0;
      bus.m_ready = 1'b1;
      for (int i = 0; i < (1 << AW); i++) mem[i] = word(AW'(i));
      test_reset();
      test_basic_burst();
      test_wrap();
      test_backpressure();
      test_zero_and_ignored();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation still running at 200000 required finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
